// File: rtl/player_input_conditioner.sv
// rtl/player_input_conditioner.sv - two-player button synchronizer, debouncer, move cancel and shoot pulse/cooldown
module player_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int COOLDOWN_CYCLES = 6250000
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       enable_i,
    input  logic [3:0] player_1_move_raw_i,
    input  logic [3:0] player_2_move_raw_i,
    input  logic       player_1_shoot_raw_i,
    input  logic       player_2_shoot_raw_i,
    output logic [3:0] player_1_move_o,
    output logic [3:0] player_2_move_o,
    output logic       player_1_shoot_o,
    output logic       player_2_shoot_o
);

    // Bit map of the packed input vector:
    //   [3:0] player 1 move, [7:4] player 2 move, [8] player 1 shoot, [9] player 2 shoot
    localparam int NUM_IN = 10;
    localparam int P1_SHOOT = 8;
    localparam int P2_SHOOT = 9;

    // Mismatch counter never exceeds DEBOUNCE_CYCLES-1: it is cleared on the
    // edge that accepts the new level, so it cannot wrap.
    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

    // Cooldown counter only has to hold COOLDOWN_CYCLES-1; keep at least one bit
    // so the design still elaborates when the cooldown is disabled.
    localparam int CDW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam logic [CDW-1:0] CD_LOAD = (COOLDOWN_CYCLES > 0) ? CDW'(COOLDOWN_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        SHOOT_READY    = 2'd0,
        SHOOT_FIRE     = 2'd1,
        SHOOT_COOLDOWN = 2'd2
    } shoot_state_t;

    logic [NUM_IN-1:0] raw_in;
    logic [NUM_IN-1:0] sync_meta;
    logic [NUM_IN-1:0] sync_q;
    logic [NUM_IN-1:0] deb_q;
    logic [NUM_IN-1:0] deb_load;
    logic [DCW-1:0]    mis_cnt_q [NUM_IN];
    logic [1:0]        shoot_rise;
    logic [1:0]        shoot_pulse;

    assign raw_in = {player_2_shoot_raw_i, player_1_shoot_raw_i,
                     player_2_move_raw_i, player_1_move_raw_i};

    // Up/down and left/right pressed together cancel each other out.
    function automatic logic [3:0] cancel_opposites(input logic [3:0] dir);
        logic [3:0] res;
        res = dir;
        if (dir[0] && dir[1]) begin
            res[1:0] = 2'b00;
        end
        if (dir[2] && dir[3]) begin
            res[3:2] = 2'b00;
        end
        return res;
    endfunction

    // Two-flop synchronizer on every raw button before anything else looks at it.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= raw_in;
            sync_q    <= sync_meta;
        end
    end

    // A debounced bit accepts the synchronized level on the edge that completes
    // DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_comb begin
        deb_load = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            deb_load[i] = (sync_q[i] != deb_q[i]) && (mis_cnt_q[i] == DEB_LAST);
        end
    end

    // Debounced state and per-input mismatch counters.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            deb_q <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                mis_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (sync_q[i] == deb_q[i]) begin
                    mis_cnt_q[i] <= '0;
                end else if (deb_load[i]) begin
                    deb_q[i]     <= sync_q[i];
                    mis_cnt_q[i] <= '0;
                end else begin
                    mis_cnt_q[i] <= mis_cnt_q[i] + DCW'(1);
                end
            end
        end
    end

    // A shoot press is the edge on which the debounced shoot bit goes 0 -> 1.
    assign shoot_rise = {deb_load[P2_SHOOT] & sync_q[P2_SHOOT],
                         deb_load[P1_SHOOT] & sync_q[P1_SHOOT]};

    // Move levels come straight from the debounced registers, gated by enable.
    always_comb begin
        player_1_move_o = '0;
        player_2_move_o = '0;
        if (enable_i) begin
            player_1_move_o = cancel_opposites(deb_q[3:0]);
            player_2_move_o = cancel_opposites(deb_q[7:4]);
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_shoot
        shoot_state_t   state_q;
        shoot_state_t   state_d;
        logic [CDW-1:0] cd_q;
        logic [CDW-1:0] cd_d;
        logic           pulse_q;

        // Shoot FSM state, cooldown counter and registered FIRE decode.
        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                state_q <= SHOOT_READY;
                cd_q    <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cd_q    <= cd_d;
                pulse_q <= (state_d == SHOOT_FIRE);
            end
        end

        // Presses seen outside READY are dropped; disabling the game aborts any cooldown.
        always_comb begin
            state_d = state_q;
            cd_d    = cd_q;
            if (!enable_i) begin
                state_d = SHOOT_READY;
                cd_d    = '0;
            end else begin
                case (state_q)
                    SHOOT_READY: begin
                        if (shoot_rise[p]) begin
                            state_d = SHOOT_FIRE;
                        end
                    end
                    SHOOT_FIRE: begin
                        if (COOLDOWN_CYCLES == 0) begin
                            state_d = SHOOT_READY;
                        end else begin
                            state_d = SHOOT_COOLDOWN;
                            cd_d    = CD_LOAD;
                        end
                    end
                    SHOOT_COOLDOWN: begin
                        if (cd_q == '0) begin
                            state_d = SHOOT_READY;
                        end else begin
                            cd_d = cd_q - CDW'(1);
                        end
                    end
                    default: begin
                        state_d = SHOOT_READY;
                        cd_d    = '0;
                    end
                endcase
            end
        end

        assign shoot_pulse[p] = pulse_q;
    end

    assign player_1_shoot_o = shoot_pulse[0];
    assign player_2_shoot_o = shoot_pulse[1];

endmodule

// File: doc/player_input_conditioner.md
PLAYER_INPUT_CONDITIONER -- requirements
Module: player_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, consecutive stable cycles required to accept an input change (legal range >= 1).
REQ-002 SHALL have parameter COOLDOWN_CYCLES, default 6250000, minimum cycles between shoot pulses of one player after the pulse cycle (legal range >= 0).
REQ-003 SHALL have port clk_i  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable_i  input  1  synchronous game-active qualifier.
REQ-006 SHALL have port player_1_move_raw_i  input  4  raw button levels, asynchronous to clk_i; bit0 up, bit1 down, bit2 left, bit3 right.
REQ-007 SHALL have port player_2_move_raw_i  input  4  same encoding as REQ-006.
REQ-008 SHALL have port player_1_shoot_raw_i  input  1  raw shoot button level, asynchronous.
REQ-009 SHALL have port player_2_shoot_raw_i  input  1  raw shoot button level, asynchronous.
REQ-010 SHALL have port player_1_move_o  output  4  conditioned move levels for the game core.
REQ-011 SHALL have port player_2_move_o  output  4  conditioned move levels.
REQ-012 SHALL have port player_1_shoot_o  output  1  single-cycle shoot pulse.
REQ-013 SHALL have port player_2_shoot_o  output  1  single-cycle shoot pulse.

Function
REQ-014 SHALL pass each of the 10 raw inputs through its own 2-flop synchronizer before any other use.
REQ-015 SHALL keep, per input, a debounced state and a mismatch counter: counter increments each cycle the synchronized value differs from debounced state, clears on any cycle they match.
REQ-016 SHALL, when a mismatch persists DEBOUNCE_CYCLES consecutive cycles, load the debounced state with the synchronized value and clear the counter in that same edge.
REQ-017 SHALL size each mismatch counter to $clog2(DEBOUNCE_CYCLES+1) bits; the counter never wraps.
REQ-018 SHALL therefore update a debounced state on the (2+DEBOUNCE_CYCLES)-th rising edge after a raw level change held steady; a glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no change.
REQ-019 SHALL drive move outputs from registered debounced move states, with opposite-direction cancellation: if up and down are both set, both bits output 0; likewise left and right; other bits unaffected.
REQ-020 SHALL force all four outputs to 0 while enable_i is 0 (move outputs combinationally gated; shoot FSMs per REQ-024).
REQ-021 SHALL implement one shoot FSM per player with states READY, FIRE, COOLDOWN.
REQ-022 SHALL transition READY -> FIRE on a debounced shoot rising edge (debounced state 0 -> 1 at this edge) when enable_i is 1; FIRE lasts exactly one cycle; FIRE -> COOLDOWN loading cooldown counter with COOLDOWN_CYCLES-1, or FIRE -> READY if COOLDOWN_CYCLES is 0; COOLDOWN decrements and goes to READY on the cycle the counter is 0.
REQ-023 SHALL drive player_N_shoot_o as a registered decode of state FIRE; edges arriving in FIRE or COOLDOWN SHALL be discarded, not queued; holding the button SHALL yield exactly one pulse.
REQ-024 SHALL, when enable_i is 0, force both FSMs to READY and clear cooldown counters on the next edge; debouncers keep running.
REQ-025 SHALL treat both players fully independently; simultaneous presses SHALL produce pulses in the same cycle.

Reset
REQ-026 SHALL, while reset_ni is 0, asynchronously clear all synchronizer flops, debounced states, mismatch counters and cooldown counters, set both FSMs to READY, and drive every output 0.
REQ-027 SHALL, after reset release with a raw button already held, treat it as a 0 -> 1 change (debounce then one shoot pulse or move assertion); reset mid-cooldown SHALL discard the cooldown.

Verification (DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8)
REQ-028 SHALL cover: player_1_move_raw_i 0000 -> 0001 held -> player_1_move_o = 0001 exactly 6 edges later; 3-cycle pulse to 0010 -> output stays 0000.
REQ-029 SHALL cover: player_2_move_raw_i = 0011 held -> player_2_move_o = 0000; raw 1101 -> output 0001.
REQ-030 SHALL cover: player_1_shoot_raw_i held high 40 cycles -> exactly one single-cycle pulse on player_1_shoot_o.
REQ-031 SHALL cover: press, release, re-press with debounced re-edge 5 cycles after pulse -> no second pulse; re-edge 10 cycles after pulse -> second pulse.
REQ-032 SHALL cover: both shoot buttons pressed in the same cycle -> both pulses in the same cycle; enable_i = 0 during press -> no pulse, all outputs 0.
REQ-033 SHALL cover: reset_ni asserted mid-cooldown and mid-debounce -> all outputs 0 immediately, without a clock edge; fresh press after release yields pulse without waiting for old cooldown.
